// File: rtl/gt_cmp_arbiter.sv
// Round-robin arbiter sharing one 2-bit greater-than comparator among NREQ requesters.
// Each grant runs IDLE -> CMP -> RESP and ends with a one-cycle done pulse tagged by requester.

module gt_cmp2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);
    assign gt = (a > b);
endmodule

module gt_cmp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] a_in,
    input  logic [2*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic [IDW-1:0]    done_id,
    output logic [7:0]        done_cnt
);
    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t                 state;
    logic [IDW-1:0]         ptr, cur_id;
    logic [IDW-1:0]         hi_id, lo_id, win_id;
    logic                   hi_found;
    logic [NREQ-1:0][1:0]   a_vec, b_vec;
    logic [1:0]             win_a, win_b, op_a, op_b;
    logic                   cmp_gt;

    assign a_vec = a_in;
    assign b_vec = b_in;
    assign busy  = (state != IDLE);

    // Rotating priority: lowest set bit at or above ptr, else wrap to the lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_id = IDW'(j);
                if (IDW'(j) >= ptr) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(j);
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
        win_a  = '0;
        win_b  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (IDW'(j) == win_id) begin
                win_a = a_vec[j];
                win_b = b_vec[j];
            end
        end
    end

    // Comparator only ever sees the operands latched at grant.
    gt_cmp2 u_cmp (
        .a  (op_a),
        .b  (op_b),
        .gt (cmp_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cur_id   <= '0;
            gnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            done     <= 1'b0;
            result   <= 1'b0;
            done_id  <= '0;
            done_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= NREQ'(1) << win_id;
                        op_a   <= win_a;
                        op_b   <= win_b;
                        cur_id <= win_id;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    result  <= cmp_gt;
                    done_id <= cur_id;
                    done    <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    done     <= 1'b0;
                    gnt      <= '0;
                    ptr      <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
                    done_cnt <= done_cnt + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gt_cmp_arbiter.sv
// Randomized and directed bench for gt_cmp_arbiter against a transaction-level reference model.

module tb_gt_cmp_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] a_in = '0;
    logic [2*NREQ-1:0] b_in = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy, done, result;
    logic [IDW-1:0]    done_id;
    logic [7:0]        done_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: an in-flight transaction with a cycle countdown.
    int m_ptr, m_cnt, m_age, m_id, m_res_pend, m_res, m_did;
    bit m_active;

    gt_cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .done_id  (done_id),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_age = 0; m_id = 0;
        m_res_pend = 0; m_res = 0; m_did = 0; m_active = 0;
    endtask

    // Called at each rising edge with the inputs sampled at that edge.
    task automatic model_edge();
        if (!m_active) begin
            if (req != 0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (req[idx]) m_id = idx;
                end
                m_res_pend = (((a_in >> (2 * m_id)) & 3) > ((b_in >> (2 * m_id)) & 3)) ? 1 : 0;
                m_active = 1;
                m_age = 1;
            end
        end else begin
            m_age++;
            if (m_age == 2) begin
                m_res = m_res_pend;
                m_did = m_id;
            end else begin
                m_active = 0;
                m_age = 0;
                m_ptr = (m_id + 1) % NREQ;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    task automatic compare();
        chk("gnt", 32'(gnt), m_active ? (32'd1 << m_id) : 32'd0);
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), (m_active && m_age == 2) ? 32'd1 : 32'd0);
        chk("result", 32'(result), 32'(m_res));
        chk("done_id", 32'(done_id), 32'(m_did));
        chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic one_txn(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] a,
                           input logic [2*NREQ-1:0] b);
        req = r; a_in = a; b_in = b;
        step();
        req = '0;
        step();
        step();
    endtask

    initial begin
        model_reset();
        #1;
        compare();
        do_reset();

        // Single request on requester 0: A=2 > B=1.
        one_txn(4'b0001, 8'b10, 8'b01);
        chk("first_cnt", 32'(done_cnt), 32'd1);
        chk("first_busy", 32'(busy), 32'd0);

        // Exhaustive operand sweep on requester 2.
        do_reset();
        for (int p = 0; p < 16; p++) begin
            logic [2*NREQ-1:0] a, b;
            a = '0; b = '0;
            a[5:4] = 2'(p >> 2);
            b[5:4] = 2'(p & 3);
            req = 4'b0100; a_in = a; b_in = b;
            step();
            req = '0;
            step();
            chk("sweep_res", 32'(result), ((p >> 2) > (p & 3)) ? 32'd1 : 32'd0);
            step();
        end
        chk("sweep_cnt", 32'(done_cnt), 32'd16);

        // All requesters held high: served 0,1,2,3,0,...
        do_reset();
        req = 4'b1111; a_in = 8'b00_01_10_11; b_in = 8'b01_00_11_10;
        for (int t = 0; t < 8; t++) begin
            step(); step(); step();
            chk("rr_id", 32'(done_id), 32'(t % NREQ));
        end
        req = '0;

        // Operands latched at grant: A changes right after grant.
        do_reset();
        req = 4'b0010; a_in = 8'b00_00_11_00; b_in = '0;
        step();
        req = '0; a_in = '0;
        step();
        chk("latch_res", 32'(result), 32'd1);
        step();

        // Reset during CMP aborts with no done and no count.
        do_reset();
        req = 4'b0100; a_in = 8'hff; b_in = '0;
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("abort_done", 32'(done), 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        one_txn(4'b1010, 8'b00_00_11_00, 8'b00_00_01_00);
        chk("after_abort_id", 32'(done_id), 32'd1);

        // Randomized traffic.
        do_reset();
        for (int t = 0; t < 600; t++) begin
            req  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            a_in = (2*NREQ)'($urandom);
            b_in = (2*NREQ)'($urandom);
            step();
        end

        // done_cnt wrap at 256 completions.
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 256 * 3; t++) begin
            a_in = (2*NREQ)'($urandom);
            b_in = (2*NREQ)'($urandom);
            step();
        end
        chk("wrap_cnt0", 32'(done_cnt), 32'd0);
        step(); step(); step();
        chk("wrap_cnt1", 32'(done_cnt), 32'd1);
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
